psk_packetizer: RTL and testbench
=================================

# psk_packetizer

Transmit-side framer for the PSK link. It accepts payload bytes on an AXI-Stream-style interface and emits one PSK symbol per symbol-rate clock enable, in BPSK (1 bit) or QPSK (2 bits). Each frame is preamble, then a 13-symbol Barker sync word, then the payload, then a silent guard interval. It sits ahead of the Tx modulator/DAC path and produces exactly the frame structure that the receive chain's SD/PD/BD detection and depacketizer consume.

## Interface
Parameters:
- PREAMBLE_LEN, 32: preamble length in symbols; legal range 1..255.
- GUARD_LEN, 8: guard length in symbol periods; legal range 1..255.
- BARKER_CODE, 13'b1111100110101: sync word, sent MSB first.

Ports:
- clk_32M768  in  1  system clock.
- rst_n_32M768  in  1  reset, asynchronous, active-low.
- clk_enable  in  1  one-cycle symbol strobe at 1.024 MHz.
- data_tdata  in  8  payload byte.
- data_tvalid  in  1  byte valid.
- data_tready  out  1  byte accepted when tvalid & tready.
- data_tlast  in  1  last byte of frame.
- data_tuser  in  1  mode, sampled on the first beat of a frame only: 1 = BPSK, 0 = QPSK.
- BPSK  out  1  current BPSK symbol.
- QPSK  out  2  current QPSK symbol, {I,Q}.
- sym_valid  out  1  high for the whole period of each transmitted symbol.
- is_bpsk  out  1  latched frame mode.
- tx_busy  out  1  state != IDLE.
- underrun  out  1  one-cycle pulse on payload starvation.

## Operation
- One-deep holding register (byte, last, user, hold_valid).
- data_tready = ~hold_valid in IDLE/PREAMBLE/BARKER/PAYLOAD; 1 in FLUSH; 0 in GUARD.
- States advance only on clk_enable cycles, except FLUSH exit.
- IDLE: on a clk_enable with hold_valid:
  - latch is_bpsk = hold user;
  - emit preamble symbol 0;
  - go to PREAMBLE.
- PREAMBLE: PREAMBLE_LEN symbols, alternating and starting with 1.
  - BPSK: 1,0,1,…
  - QPSK: 11,00,11,…
  - Then go to BARKER.
- BARKER: 13 symbols, bit b of BARKER_CODE sent MSB first.
  - BPSK: b.
  - QPSK: {b,b}.
  - Then go to PAYLOAD, loading the shift register from hold.
- PAYLOAD: bytes are sent MSB first.
  - BPSK: 8 symbols per byte, d7 first.
  - QPSK: 4 symbols per byte, {d7,d6} first.
- At each byte boundary (clk_enable after the last symbol of a byte):
  - current byte had last → GUARD;
  - else hold_valid → load hold and emit its first symbol;
  - else pulse underrun and go to FLUSH.
- FLUSH: sym_valid = 0; discard accepted beats. The beat with tlast → GUARD on the next cycle.
- GUARD: sym_valid = 0, BPSK = 0, QPSK = 0 for GUARD_LEN symbol periods, then go to IDLE.
- Outputs in BPSK mode: QPSK = {BPSK,BPSK}. In QPSK mode: BPSK = QPSK[1].

## Timing
- Reset (async assert, synchronous deassert by the clock) clears:
  - state = IDLE, hold_valid = 0, counters = 0;
  - BPSK = 0, QPSK = 0, sym_valid = 0, is_bpsk = 0, tx_busy = 0, underrun = 0;
  - data_tready = 1 after reset.
- All outputs are registered.
- A symbol chosen on clk_enable cycle N appears at N+1 and holds until the next clk_enable.
- Latency: first beat accepted at cycle A → first preamble symbol one cycle after the first clk_enable strictly after A.
- Hold write and symbol-boundary load in the same cycle: the load sees the old hold_valid (no bypass).
  - Mid-payload, this gives underrun.
  - In IDLE, the frame starts at the following clk_enable.
- Symbol counter: 8 bits; bit index: 3 bits; BPSK wraps at 7, QPSK at 3.
- Frame-level data_tuser is ignored after the first beat.
- sym_valid drops exactly one cycle after the clk_enable that ends the last payload symbol.
- Reset mid-frame aborts immediately: outputs return to reset values and the held byte is lost.

## Test plan
- BPSK frame, PREAMBLE_LEN=4, GUARD_LEN=2, single beat 0xA5 with tlast and tuser=1 → exactly 25 valid symbols: 1010, 1111100110101, 10100101; then sym_valid=0 for 2 periods; then tx_busy=0.
- QPSK frame, one beat 0x1B with tuser=0 → payload QPSK 00,01,10,11; Barker symbols 11/00 pairs; is_bpsk=0 throughout.
- Back-to-back 3-byte BPSK frame with tvalid held high → 24 contiguous payload symbols, no gaps, no underrun pulse.
- Byte 2 withheld past its boundary → underrun pulses once and sym_valid=0. Further beats are then accepted and dropped; tlast → guard, then idle.
- Async reset asserted mid-payload → all outputs 0 in the same cycle; the next frame transmits cleanly.
- Beat presented on the same cycle as a byte-boundary clk_enable → underrun (no bypass).

Source files
------------

// File: rtl/psk_packetizer_if.sv
// rtl/psk_packetizer_if.sv - payload byte stream feeding the PSK packetizer
interface psk_packetizer_if;
  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tready;
  logic       data_tlast;
  logic       data_tuser;

  modport master (output data_tdata, data_tvalid, data_tlast, data_tuser, input data_tready);
  modport slave  (input data_tdata, data_tvalid, data_tlast, data_tuser, output data_tready);
endinterface

// File: rtl/psk_packetizer.sv
// rtl/psk_packetizer.sv - frames payload bytes into preamble/Barker/payload/guard PSK symbols
module psk_packetizer #(
  parameter int          PREAMBLE_LEN = 32,
  parameter int          GUARD_LEN    = 8,
  parameter logic [12:0] BARKER_CODE  = 13'b1111100110101
) (
  input  logic              clk_32M768,
  input  logic              rst_n_32M768,
  input  logic              clk_enable,
  psk_packetizer_if.slave   axis,
  output logic              BPSK,
  output logic [1:0]        QPSK,
  output logic              sym_valid,
  output logic              is_bpsk,
  output logic              tx_busy,
  output logic              underrun
);
  localparam logic [7:0]  PRE_LEN    = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_LEN - 1);
  localparam logic [7:0]  BARKER_LEN = 8'd13;
  localparam logic [15:0] BARKER_EXT = {3'b000, BARKER_CODE};

  typedef enum logic [2:0] {IDLE, PREAMBLE, BARKER, PAYLOAD, FLUSH, GUARD} state_t;

  state_t     state;
  logic [7:0] hold_byte;
  logic       hold_last;
  logic       hold_user;
  logic       hold_valid;
  logic [7:0] shift_reg;
  logic       cur_last;
  logic [7:0] sym_cnt;
  logic [2:0] bit_idx;

  logic       accept;
  logic       byte_done;
  logic [2:0] bit_wrap;
  logic [1:0] load_sym;
  logic [7:0] load_shift;
  logic       barker_bit;
  logic [1:0] sym_next;
  logic       sym_emit;

  assign axis.data_tready = (state == GUARD) ? 1'b0 : (state == FLUSH) ? 1'b1 : ~hold_valid;
  assign accept     = axis.data_tvalid & axis.data_tready;
  assign bit_wrap   = is_bpsk ? 3'd7 : 3'd3;
  assign byte_done  = (bit_idx == bit_wrap);
  assign load_sym   = is_bpsk ? {2{hold_byte[7]}} : hold_byte[7:6];
  assign load_shift = is_bpsk ? {hold_byte[6:0], 1'b0} : {hold_byte[5:0], 2'b00};
  assign barker_bit = BARKER_EXT[4'd12 - sym_cnt[3:0]];

  // Symbol chosen for the next clk_enable; silent periods carry zeros.
  always_comb begin
    sym_next = 2'b00;
    sym_emit = 1'b0;
    case (state)
      IDLE: if (hold_valid) begin
        sym_next = 2'b11;
        sym_emit = 1'b1;
      end
      PREAMBLE: begin
        sym_next = (sym_cnt == PRE_LEN) ? {2{BARKER_CODE[12]}} : {2{~sym_cnt[0]}};
        sym_emit = 1'b1;
      end
      BARKER: begin
        sym_next = (sym_cnt == BARKER_LEN) ? load_sym : {2{barker_bit}};
        sym_emit = 1'b1;
      end
      PAYLOAD: if (!byte_done) begin
        sym_next = is_bpsk ? {2{shift_reg[7]}} : shift_reg[7:6];
        sym_emit = 1'b1;
      end else if (!cur_last && hold_valid) begin
        sym_next = load_sym;
        sym_emit = 1'b1;
      end
      default: begin
        sym_next = 2'b00;
        sym_emit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      state      <= IDLE;
      hold_byte  <= 8'h00;
      hold_last  <= 1'b0;
      hold_user  <= 1'b0;
      hold_valid <= 1'b0;
      shift_reg  <= 8'h00;
      cur_last   <= 1'b0;
      sym_cnt    <= 8'h00;
      bit_idx    <= 3'd0;
      BPSK       <= 1'b0;
      QPSK       <= 2'b00;
      sym_valid  <= 1'b0;
      is_bpsk    <= 1'b0;
      tx_busy    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (accept && state != FLUSH) begin
        hold_byte  <= axis.data_tdata;
        hold_last  <= axis.data_tlast;
        hold_user  <= axis.data_tuser;
        hold_valid <= 1'b1;
      end
      if (clk_enable) begin
        QPSK      <= sym_next;
        BPSK      <= sym_next[1];
        sym_valid <= sym_emit;
      end
      case (state)
        IDLE: if (clk_enable && hold_valid) begin
          is_bpsk <= hold_user;
          tx_busy <= 1'b1;
          sym_cnt <= 8'd1;
          state   <= PREAMBLE;
        end
        PREAMBLE: if (clk_enable) begin
          if (sym_cnt == PRE_LEN) begin
            sym_cnt <= 8'd1;
            state   <= BARKER;
          end else begin
            sym_cnt <= sym_cnt + 8'd1;
          end
        end
        BARKER: if (clk_enable) begin
          if (sym_cnt == BARKER_LEN) begin
            shift_reg  <= load_shift;
            cur_last   <= hold_last;
            hold_valid <= 1'b0;
            bit_idx    <= 3'd0;
            state      <= PAYLOAD;
          end else begin
            sym_cnt <= sym_cnt + 8'd1;
          end
        end
        PAYLOAD: if (clk_enable) begin
          if (!byte_done) begin
            shift_reg <= is_bpsk ? {shift_reg[6:0], 1'b0} : {shift_reg[5:0], 2'b00};
            bit_idx   <= bit_idx + 3'd1;
          end else if (cur_last) begin
            sym_cnt <= 8'd0;
            state   <= GUARD;
          end else if (hold_valid) begin
            shift_reg  <= load_shift;
            cur_last   <= hold_last;
            hold_valid <= 1'b0;
            bit_idx    <= 3'd0;
          end else begin
            underrun <= 1'b1;
            state    <= FLUSH;
          end
        end
        FLUSH: begin
          // A beat that landed in hold on the underrun edge belongs to the flushed frame.
          hold_valid <= 1'b0;
          if ((hold_valid && hold_last) || (accept && axis.data_tlast)) begin
            sym_cnt <= 8'd0;
            state   <= GUARD;
          end
        end
        GUARD: if (clk_enable) begin
          if (sym_cnt == GUARD_LAST) begin
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            sym_cnt <= sym_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psk_packetizer.sv
// tb/tb_psk_packetizer.sv - scoreboard bench for psk_packetizer with PREAMBLE_LEN=4, GUARD_LEN=2
module tb_psk_packetizer;
  logic       clk_32M768   = 1'b0;
  logic       rst_n_32M768 = 1'b0;
  logic       clk_enable   = 1'b0;
  logic       BPSK;
  logic [1:0] QPSK;
  logic       sym_valid;
  logic       is_bpsk;
  logic       tx_busy;
  logic       underrun;

  psk_packetizer_if axis ();

  psk_packetizer #(.PREAMBLE_LEN(4), .GUARD_LEN(2)) dut (
    .clk_32M768   (clk_32M768),
    .rst_n_32M768 (rst_n_32M768),
    .clk_enable   (clk_enable),
    .axis         (axis.slave),
    .BPSK         (BPSK),
    .QPSK         (QPSK),
    .sym_valid    (sym_valid),
    .is_bpsk      (is_bpsk),
    .tx_busy      (tx_busy),
    .underrun     (underrun)
  );

  always #5 clk_32M768 = ~clk_32M768;

  initial begin
    int div = 0;
    forever begin
      @(negedge clk_32M768);
      div = div + 1;
      clk_enable = (div % 4 == 0);
    end
  end

  logic [2:0] exp_q[$];
  int n_cmp = 0, n_fail = 0, n_sym = 0, n_guard = 0, n_under = 0;
  logic [12:0] barker = 13'b1111100110101;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic exp_sym(input logic m, input logic [1:0] q);
    exp_q.push_back({m, q});
  endtask

  task automatic exp_bits(input logic m, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({m, v[i], v[i]});
  endtask

  // Monitor: one sample per symbol period, just after each clk_enable edge.
  initial begin
    logic ce_edge;
    logic [2:0] e;
    forever begin
      @(posedge clk_32M768);
      ce_edge = clk_enable;
      #1;
      if (underrun) n_under++;
      if (ce_edge && sym_valid) begin
        n_sym++;
        if (exp_q.size() == 0) check("unexpected_symbol", {is_bpsk, QPSK}, 3'b111 ^ {is_bpsk, QPSK});
        else begin
          e = exp_q.pop_front();
          check("symbol {is_bpsk,QPSK,BPSK}", {is_bpsk, QPSK, BPSK}, {e, e[1]});
        end
      end else if (ce_edge && tx_busy) begin
        n_guard++;
        check("silent_outputs", {BPSK, QPSK}, 3'b000);
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
    int k = 0;
    axis.data_tdata  = d;
    axis.data_tlast  = last;
    axis.data_tuser  = user;
    axis.data_tvalid = 1'b1;
    while (!axis.data_tready && k < 4000) begin @(negedge clk_32M768); k++; end
    check("beat_ready", axis.data_tready, 1);
    @(posedge clk_32M768);
    @(negedge clk_32M768);
    axis.data_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    logic seen = 1'b0;
    while (!(seen && !tx_busy) && k < 4000) begin
      @(negedge clk_32M768);
      seen = seen | tx_busy;
      k++;
    end
    check("frame_done {seen_busy,tx_busy}", {seen, tx_busy}, 2'b10);
    repeat (2) @(negedge clk_32M768);
  endtask

  task automatic wait_sym(input int target);
    int k = 0;
    while (n_sym < target && k < 4000) begin @(negedge clk_32M768); k++; end
    check("symbol_count_reached", n_sym >= target, 1);
  endtask

  initial begin
    int base, ubase;
    axis.data_tdata  = 8'h00;
    axis.data_tvalid = 1'b0;
    axis.data_tlast  = 1'b0;
    axis.data_tuser  = 1'b0;

    @(posedge clk_32M768);
    #1;
    check("reset_outputs", {BPSK, QPSK, sym_valid, is_bpsk, tx_busy, underrun}, 7'd0);
    check("reset_tready", axis.data_tready, 1);
    repeat (2) @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;
    repeat (2) @(negedge clk_32M768);

    // Single-beat BPSK frame 0xA5
    base = n_sym; n_guard = 0;
    exp_bits(1, 4'b1010, 4); exp_bits(1, barker, 13); exp_bits(1, 8'hA5, 8);
    send_beat(8'hA5, 1, 1);
    wait_idle();
    check("bpsk_symbols", n_sym - base, 25);
    check("bpsk_guard_periods", n_guard, 2);
    check("bpsk_queue_drained", exp_q.size(), 0);

    // Three back-to-back beats; later tuser values must be ignored
    base = n_sym; n_guard = 0; ubase = n_under;
    exp_bits(1, 4'b1010, 4); exp_bits(1, barker, 13);
    exp_bits(1, 8'hC3, 8); exp_bits(1, 8'h5A, 8); exp_bits(1, 8'h0F, 8);
    send_beat(8'hC3, 0, 1);
    send_beat(8'h5A, 0, 0);
    send_beat(8'h0F, 1, 0);
    wait_idle();
    check("b2b_symbols", n_sym - base, 41);
    check("b2b_no_gaps", n_guard, 2);
    check("b2b_no_underrun", n_under - ubase, 0);
    check("b2b_queue_drained", exp_q.size(), 0);

    // Second byte withheld: underrun, then flushed beats until tlast
    base = n_sym; ubase = n_under;
    exp_bits(1, 4'b1010, 4); exp_bits(1, barker, 13); exp_bits(1, 8'h3C, 8);
    send_beat(8'h3C, 0, 1);
    begin
      int k = 0;
      while (n_under == ubase && k < 4000) begin @(negedge clk_32M768); k++; end
    end
    check("starve_sym_valid_low", sym_valid, 0);
    send_beat(8'h11, 0, 0);
    send_beat(8'h22, 1, 0);
    wait_idle();
    check("starve_underrun_once", n_under - ubase, 1);
    check("starve_symbols", n_sym - base, 25);
    check("starve_queue_drained", exp_q.size(), 0);

    // Beat arriving on the byte-boundary clk_enable is not bypassed
    base = n_sym; ubase = n_under;
    exp_bits(1, 4'b1010, 4); exp_bits(1, barker, 13); exp_bits(1, 8'h81, 8);
    send_beat(8'h81, 0, 1);
    wait_sym(base + 25);
    repeat (3) @(negedge clk_32M768);
    send_beat(8'h99, 1, 1);
    wait_idle();
    check("nobypass_underrun", n_under - ubase, 1);
    check("nobypass_symbols", n_sym - base, 25);
    check("nobypass_queue_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of the payload
    base = n_sym;
    exp_bits(1, 4'b1010, 4); exp_bits(1, barker, 13); exp_bits(1, 8'hFF, 8);
    send_beat(8'hFF, 1, 1);
    wait_sym(base + 19);
    #2 rst_n_32M768 = 1'b0;
    #1;
    check("abort_outputs", {BPSK, QPSK, sym_valid, is_bpsk, tx_busy, underrun}, 7'd0);
    check("abort_tready", axis.data_tready, 1);
    exp_q.delete();
    repeat (3) @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;
    repeat (2) @(negedge clk_32M768);

    // QPSK frame 0x1B after the abort
    base = n_sym;
    exp_sym(0, 2'b11); exp_sym(0, 2'b00); exp_sym(0, 2'b11); exp_sym(0, 2'b00);
    exp_bits(0, barker, 13);
    exp_sym(0, 2'b00); exp_sym(0, 2'b01); exp_sym(0, 2'b10); exp_sym(0, 2'b11);
    send_beat(8'h1B, 1, 0);
    wait_idle();
    check("qpsk_symbols", n_sym - base, 21);
    check("qpsk_queue_drained", exp_q.size(), 0);
    check("qpsk_mode_latched", is_bpsk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
